shake_squeeze_collector: RTL and testbench
==========================================

// Module: shake_squeeze_collector
// PURPOSE
// - Downstream of keccak_top: consumes SHAKE squeeze words (WOUT bits, valid/ready), packs them into WIDE-bit words for the sampler/expander.
// - Counts delivered wide words; after out_len words, drives force_done to stop squeezing and waits for force_done_ack.
// PARAMETERS
// - WOUT   32   width of keccak_top dout; WIDE % WOUT == 0
// - WIDE   128  packed output width; RATIO = WIDE/WOUT lanes (>=1)
// - LEN_W  16   width of out_len / word counter
// PORTS
// - clk               in   1      clock, all logic on rising edge
// - rst               in   1      reset, asynchronous, active-high
// - start             in   1      1-cycle request; samples out_len
// - out_len           in   LEN_W  number of WIDE words to deliver
// - sqz_dout          in   WOUT   keccak_top dout
// - sqz_dout_valid    in   1      keccak_top dout_valid
// - sqz_dout_ready    out  1      to keccak_top dout_ready
// - force_done        out  1      to keccak_top force_done (level)
// - force_done_ack    in   1      from keccak_top force_done_ack (level, force_done delayed 2 clk)
// - wide_dout         out  WIDE   packed word
// - wide_valid        out  1      wide_dout valid
// - wide_ready        in   1      consumer ready
// - busy              out  1      high in any state but IDLE
// - done              out  1      1-cycle pulse when request complete
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, lane/word counters 0, pack and output registers 0. Reset mid-operation aborts immediately; no done pulse.
// - States: IDLE -> COLLECT -> STOP -> FIN -> IDLE.
// - IDLE: start && !force_done_ack -> latch out_len; out_len==0 -> STOP, else COLLECT. start while busy or while force_done_ack==1 is ignored.
// - COLLECT: sqz_dout_ready = (lane<RATIO) && (words_issued<len). Word accepted on valid&&ready into lane slot; lane 0 = bits [WOUT-1:0] (first word in LSBs).
// - When lane reaches RATIO and output register empty (or being drained this cycle), pack reg -> wide_dout, wide_valid=1 next cycle, lane=0, words_issued++. Zero-bubble: a squeeze word may be accepted into lane 0 in that same cycle.
// - wide_valid held with wide_dout stable until wide_ready; words_sent++ on each wide handshake.
// - words_sent==len after a handshake (wide_valid 0) -> STOP. Extra squeeze words are never accepted (ready 0 once words_issued==len).
// - STOP: force_done=1, sqz_dout_ready=0; hold until force_done_ack==1, then force_done=0 -> FIN.
// - FIN: done=1 for exactly one cycle -> IDLE.
// - Latency: last lane accepted at cycle t -> wide_valid at t+1; wide handshake at t' -> force_done at t'+1; ack (2 clk later) -> done 2 clk after ack.
// - Counters are LEN_W bits, never wrap (max out_len = 2^LEN_W-1).
// CONFIGURATION
// - SQZ_BYTE_SWAP_EN defined: each WOUT word byte-reversed before packing (byte 0 of sqz_dout -> MSB byte of its lane).
// - Not defined: words packed unchanged. Handshake timing identical in both builds.
// TESTING
// - RATIO=4, out_len=2, sqz words 0x1..0x8 back-to-back, wide_ready=1 -> wide_dout 0x00000004_00000003_00000002_00000001 then 0x8_7_6_5, force_done 1 cycle later, done pulse; exactly 8 words accepted.
// - Same, wide_ready held 0 for 10 cycles on first word -> wide_dout stable, sqz_dout_ready drops after lanes fill, no word lost or duplicated.
// - out_len=0 start -> no sqz_dout_ready, force_done until ack, single done pulse, zero wide_valid.
// - start asserted during COLLECT and while force_done_ack still high -> ignored, busy/len unchanged.
// - rst pulsed mid-COLLECT (lane=2) -> all outputs 0 asynchronously, next start restarts cleanly from lane 0.
// - SQZ_BYTE_SWAP_EN build: word 0x11223344 in lane 0 -> wide_dout[31:0]=0x44332211.

Source files
------------

// File: rtl/shake_squeeze_collector.sv
// Packs WOUT-bit SHAKE squeeze words into WIDE-bit words and stops the squeeze after out_len words.
// Optional build macro SQZ_BYTE_SWAP_EN byte-reverses every squeeze word before packing.
module shake_squeeze_collector #(
  parameter int WOUT  = 32,
  parameter int WIDE  = 128,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] out_len,
  input  logic [WOUT-1:0]  sqz_dout,
  input  logic             sqz_dout_valid,
  output logic             sqz_dout_ready,
  output logic             force_done,
  input  logic             force_done_ack,
  output logic [WIDE-1:0]  wide_dout,
  output logic             wide_valid,
  input  logic             wide_ready,
  output logic             busy,
  output logic             done
);

  localparam int RATIO  = WIDE / WOUT;
  localparam int LANE_W = $clog2(RATIO + 1);
  localparam logic [LANE_W-1:0] LANE_FULL = LANE_W'(RATIO);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, STOP, FIN} state_t;

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  words_issued;
  logic [LEN_W-1:0]  words_sent;
  logic [LANE_W-1:0] lane;
  logic [WIDE-1:0]   pack_reg;
  logic [WIDE-1:0]   pack_next;
  logic [WOUT-1:0]   in_word;
  logic [LEN_W:0]    len_ext;
  logic [LEN_W:0]    issued_inc;
  logic [LEN_W:0]    sent_inc;
  logic              out_free;
  logic              wide_hs;
  logic              lane_full;
  logic              accept;
  logic              load_full;
  logic              load_last;
  logic              last_hs;

`ifdef SQZ_BYTE_SWAP_EN
  always_comb begin
    in_word = '0;
    for (int b = 0; b < WOUT / 8; b++)
      in_word[(WOUT/8 - 1 - b)*8 +: 8] = sqz_dout[b*8 +: 8];
  end
`else
  assign in_word = sqz_dout;
`endif

  assign out_free   = !wide_valid || wide_ready;
  assign wide_hs    = wide_valid && wide_ready;
  assign lane_full  = (lane == LANE_FULL);
  assign len_ext    = {1'b0, len};
  assign issued_inc = {1'b0, words_issued} + (LEN_W+1)'(1);
  assign sent_inc   = {1'b0, words_sent} + (LEN_W+1)'(1);

  // A full pack register may take a new lane-0 word only while it drains and more words remain.
  always_comb begin
    sqz_dout_ready = 1'b0;
    if (state == COLLECT) begin
      if (lane_full) sqz_dout_ready = out_free && (issued_inc < len_ext);
      else           sqz_dout_ready = (words_issued < len);
    end
  end

  assign accept    = sqz_dout_valid && sqz_dout_ready;
  assign load_full = (state == COLLECT) && lane_full && out_free;
  assign load_last = accept && (lane == LANE_LAST) && out_free;
  assign last_hs   = wide_hs && (sent_inc == len_ext);

  always_comb begin
    pack_next = pack_reg;
    for (int i = 0; i < RATIO; i++)
      if (accept && (lane_full ? (i == 0) : (lane == LANE_W'(i))))
        pack_next[i*WOUT +: WOUT] = in_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      words_issued <= '0;
      words_sent   <= '0;
      lane         <= '0;
      pack_reg     <= '0;
      wide_dout    <= '0;
      wide_valid   <= 1'b0;
      force_done   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !force_done_ack) begin
            len          <= out_len;
            words_issued <= '0;
            words_sent   <= '0;
            lane         <= '0;
            busy         <= 1'b1;
            if (out_len == '0) begin
              state      <= STOP;
              force_done <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (accept) pack_reg <= pack_next;
          if (load_full)      wide_dout <= pack_reg;
          else if (load_last) wide_dout <= pack_next;
          if (load_full || load_last) begin
            wide_valid   <= 1'b1;
            words_issued <= words_issued + LEN_W'(1);
          end else if (wide_hs) begin
            wide_valid <= 1'b0;
          end
          if (wide_hs) words_sent <= words_sent + LEN_W'(1);
          if (load_full)      lane <= accept ? LANE_W'(1) : '0;
          else if (load_last) lane <= '0;
          else if (accept)    lane <= lane + LANE_W'(1);
          if (last_hs) begin
            state      <= STOP;
            force_done <= 1'b1;
          end
        end
        STOP: begin
          if (force_done_ack) begin
            force_done <= 1'b0;
            state      <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_squeeze_collector.sv
// Randomized bench for shake_squeeze_collector: a transaction-level model tracks accepted squeeze
// words and requests, and a per-cycle monitor compares every DUT output against it.
module tb_shake_squeeze_collector;

  localparam int WOUT  = 32;
  localparam int WIDE  = 128;
  localparam int LEN_W = 16;
  localparam int RATIO = WIDE / WOUT;

`ifdef SQZ_BYTE_SWAP_EN
  localparam logic [WIDE-1:0] EXP0     = 128'h04000000_03000000_02000000_01000000;
  localparam logic [WIDE-1:0] EXP1     = 128'h08000000_07000000_06000000_05000000;
  localparam logic [WIDE-1:0] EXP_SWAP = 128'h44332211;
`else
  localparam logic [WIDE-1:0] EXP0     = 128'h00000004_00000003_00000002_00000001;
  localparam logic [WIDE-1:0] EXP1     = 128'h00000008_00000007_00000006_00000005;
  localparam logic [WIDE-1:0] EXP_SWAP = 128'h11223344;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] out_len;
  logic [WOUT-1:0]  sqz_dout;
  logic             sqz_dout_valid;
  logic             sqz_dout_ready;
  logic             force_done;
  logic             force_done_ack;
  logic [WIDE-1:0]  wide_dout;
  logic             wide_valid;
  logic             wide_ready;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;

  int          valid_pct = 100;
  int          ready_pct = 100;
  bit          gen_en = 0;
  bit          seq_mode = 1;
  logic [31:0] next_seq = 32'h1;
  bit          ack_hold = 0;
  logic        ack_d1, ack_d2;

  bit              active = 0;
  bit              fd_exp = 0;
  bit              expect_wv = 0;
  bit              prev_stall = 0;
  logic [WIDE-1:0] prev_dout = '0;
  int              m_len = 0;
  int              acc_cnt = 0;
  int              sent_cnt = 0;
  int              cyc = 0;
  int              done_at = -1;
  int              done_cnt = 0;
  logic [WOUT-1:0] accq[$];
  logic [WIDE-1:0] wlog[$];

  shake_squeeze_collector #(.WOUT(WOUT), .WIDE(WIDE), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .out_len        (out_len),
    .sqz_dout       (sqz_dout),
    .sqz_dout_valid (sqz_dout_valid),
    .sqz_dout_ready (sqz_dout_ready),
    .force_done     (force_done),
    .force_done_ack (force_done_ack),
    .wide_dout      (wide_dout),
    .wide_valid     (wide_valid),
    .wide_ready     (wide_ready),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [WIDE-1:0] act, input logic [WIDE-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WOUT-1:0] lane_image(input logic [WOUT-1:0] w);
    logic [WOUT-1:0] r;
`ifdef SQZ_BYTE_SWAP_EN
    for (int b = 0; b < WOUT / 8; b++) r[(WOUT/8 - 1 - b)*8 +: 8] = w[b*8 +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  // Keccak side: ack follows force_done two clocks later, optionally held high.
  initial begin
    ack_d1 = 0;
    ack_d2 = 0;
    force_done_ack = 0;
    forever begin
      @(posedge clk);
      #1;
      force_done_ack = ack_d2 | ack_hold;
      ack_d2 = ack_d1;
      ack_d1 = force_done;
    end
  end

  // Squeeze source and wide consumer; a squeeze word is held until accepted.
  initial begin
    bit took;
    sqz_dout_valid = 0;
    sqz_dout = '0;
    wide_ready = 0;
    forever begin
      @(negedge clk);
      took = sqz_dout_valid && sqz_dout_ready;
      @(posedge clk);
      #1;
      if (!gen_en) begin
        sqz_dout_valid = 0;
      end else if (took || !sqz_dout_valid) begin
        if (int'($urandom_range(0, 99)) < valid_pct) begin
          sqz_dout_valid = 1;
          if (seq_mode) begin
            sqz_dout = next_seq;
            next_seq = next_seq + 1;
          end else begin
            sqz_dout = $urandom;
          end
        end else begin
          sqz_dout_valid = 0;
        end
      end
      wide_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  // Per-cycle monitor: the model is a request flag, counts of accepted/sent words and a word queue.
  always @(negedge clk) begin
    bit fd_set;
    int groups_before;
    logic [WIDE-1:0] exp_word;
    fd_set = 0;
    if (rst) begin
      active = 0; fd_exp = 0; expect_wv = 0; prev_stall = 0; done_at = -1;
      acc_cnt = 0; sent_cnt = 0; accq.delete();
    end else begin
      cyc++;
      checkOutput("busy", busy, active && (cyc != done_at));
      checkOutput("done", done, cyc == done_at);
      checkOutput("force_done", force_done, fd_exp);
      if (!active || fd_exp || done_at >= 0) begin
        checkOutput("sqz_ready_quiet", sqz_dout_ready, 0);
        checkOutput("wide_valid_quiet", wide_valid, 0);
      end
      if (expect_wv) checkOutput("wide_valid_latency", wide_valid, 1);
      if (prev_stall) begin
        checkOutput("wide_valid_hold", wide_valid, 1);
        checkOutput("wide_dout_hold", wide_dout, prev_dout);
      end
      expect_wv = 0;
      if (active && sqz_dout_valid && sqz_dout_ready) begin
        groups_before = acc_cnt / RATIO;
        acc_cnt++;
        accq.push_back(sqz_dout);
        checkOutput("accept_limit", acc_cnt <= m_len * RATIO, 1);
        if ((acc_cnt % RATIO == 0) && (!wide_valid || wide_ready) &&
            (groups_before == sent_cnt + int'(wide_valid)))
          expect_wv = 1;
      end
      if (active && wide_valid && wide_ready) begin
        checkOutput("wide_words_available", accq.size() >= RATIO, 1);
        if (accq.size() >= RATIO) begin
          exp_word = '0;
          for (int i = 0; i < RATIO; i++) exp_word[i*WOUT +: WOUT] = lane_image(accq.pop_front());
          checkOutput("wide_dout", wide_dout, exp_word);
        end
        wlog.push_back(wide_dout);
        sent_cnt++;
        if (sent_cnt == m_len) fd_set = 1;
      end
      prev_stall = wide_valid && !wide_ready;
      prev_dout = wide_dout;
      if (fd_exp && force_done_ack) begin
        fd_exp = 0;
        done_at = cyc + 2;
      end
      if (cyc == done_at) begin
        active = 0;
        done_at = -1;
        done_cnt++;
      end
      if (start && !active && !force_done_ack) begin
        active = 1;
        m_len = int'(out_len);
        acc_cnt = 0;
        sent_cnt = 0;
        accq.delete();
        if (out_len == '0) fd_exp = 1;
      end
      if (fd_set) fd_exp = 1;
    end
  end

  task automatic applyStimulus(input int len);
    repeat (2) @(posedge clk);
    #1;
    start = 1;
    out_len = LEN_W'(len);
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic waitDone(input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > d0) seen = 1;
    end
    checkOutput("done_within_budget", seen, 1);
  endtask

  task automatic setSource(input bit seq, input logic [31:0] first, input int vp, input int rp);
    gen_en = 0;
    repeat (2) @(posedge clk);
    #2;
    seq_mode = seq;
    next_seq = first;
    valid_pct = vp;
    ready_pct = rp;
    gen_en = 1;
  endtask

  task automatic runBasic(input string tag);
    logic [WIDE-1:0] w;
    setSource(1, 32'h1, 100, 100);
    wlog.delete();
    applyStimulus(2);
    waitDone(200);
    w = (wlog.size() > 0) ? wlog[0] : '0;
    checkOutput({tag, "_word0"}, w, EXP0);
    w = (wlog.size() > 1) ? wlog[1] : '0;
    checkOutput({tag, "_word1"}, w, EXP1);
    checkOutput({tag, "_accepted"}, acc_cnt, 8);
    checkOutput({tag, "_sent"}, sent_cnt, 2);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [WIDE-1:0] w;
    int len;
    bit hit;
    rst = 1;
    start = 0;
    out_len = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_sqz_ready", sqz_dout_ready, 0);
    checkOutput("reset_force_done", force_done, 0);
    checkOutput("reset_wide_valid", wide_valid, 0);
    checkOutput("reset_wide_dout", wide_dout, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    rst = 0;

    runBasic("basic");

    // Consumer stalls on the first wide word.
    setSource(1, 32'h1, 100, 0);
    wlog.delete();
    applyStimulus(2);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = wide_valid;
    end
    checkOutput("stall_wide_valid_seen", hit, 1);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("stall_sqz_ready_low", sqz_dout_ready, 0);
    checkOutput("stall_wide_valid", wide_valid, 1);
    checkOutput("stall_wide_dout", wide_dout, EXP0);
    ready_pct = 100;
    waitDone(200);
    w = (wlog.size() > 1) ? wlog[1] : '0;
    checkOutput("stall_word1", w, EXP1);
    checkOutput("stall_accepted", acc_cnt, 8);
    checkOutput("stall_sent", sent_cnt, 2);

    // Zero-length request.
    setSource(0, 32'h0, 100, 100);
    applyStimulus(0);
    waitDone(100);
    checkOutput("zero_len_accepted", acc_cnt, 0);
    checkOutput("zero_len_sent", sent_cnt, 0);

    // Start while ack is still high is ignored.
    ack_hold = 1;
    applyStimulus(3);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("start_ack_high_busy", busy, 0);
    ack_hold = 0;
    repeat (4) @(posedge clk);

    // Start during COLLECT is ignored.
    setSource(1, 32'h100, 100, 50);
    applyStimulus(2);
    repeat (3) @(posedge clk);
    #1;
    start = 1;
    out_len = LEN_W'(5);
    @(posedge clk);
    #1;
    start = 0;
    checkOutput("start_collect_busy", busy, 1);
    waitDone(300);
    checkOutput("start_collect_sent", sent_cnt, 2);
    checkOutput("start_collect_accepted", acc_cnt, 8);

    // Asynchronous reset with two lanes filled.
    setSource(1, 32'h1, 100, 100);
    applyStimulus(2);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = (acc_cnt >= 2);
    end
    checkOutput("midreset_two_accepted", hit, 1);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    checkOutput("midreset_sqz_ready", sqz_dout_ready, 0);
    checkOutput("midreset_wide_valid", wide_valid, 0);
    checkOutput("midreset_wide_dout", wide_dout, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_force_done", force_done, 0);
    checkOutput("midreset_done", done, 0);
    @(posedge clk);
    #1;
    rst = 0;
    runBasic("after_reset");

    // Lane 0 placement of a distinctive word.
    setSource(1, 32'h11223344, 100, 100);
    wlog.delete();
    applyStimulus(1);
    waitDone(100);
    w = (wlog.size() > 0) ? wlog[0] : '0;
    w = w & 128'hFFFFFFFF;
    checkOutput("lane0_word", w, EXP_SWAP);

    // Randomized requests.
    for (int r = 0; r < 12; r++) begin
      setSource(0, 32'h0, int'($urandom_range(30, 100)), int'($urandom_range(20, 100)));
      len = int'($urandom_range(0, 5));
      applyStimulus(len);
      waitDone(3000);
      checkOutput("rand_sent", sent_cnt, len);
      checkOutput("rand_accepted", acc_cnt, len * RATIO);
    end

    gen_en = 0;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
